// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared FSM state type and default width for serial_adder
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fulladder_cmos.sv
// rtl/fulladder_cmos.sv - one-bit full adder cell built from nine 2-input NAND gates
module fulladder_cmos (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic n1, n2, n3, axb, n4, n5, n6;

  // first half adder: axb = a ^ b, n1 = ~(a & b)
  assign n1   = ~(a & b);
  assign n2   = ~(a & n1);
  assign n3   = ~(b & n1);
  assign axb  = ~(n2 & n3);
  // second half adder against cin; carry merges both NAND carry terms
  assign n4   = ~(axb & cin);
  assign n5   = ~(axb & n4);
  assign n6   = ~(cin & n4);
  assign sum  = ~(n5 & n6);
  assign cout = ~(n1 & n4);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, LSB first, one bit per clock, valid/ready handshakes
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] areg, breg, sreg, s_next;
  logic             creg;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_c;

  fulladder_cmos u_fa (
    .a    (areg[0]),
    .b    (breg[0]),
    .cin  (creg),
    .sum  (fa_s),
    .cout (fa_c)
  );

  // new sum bit enters at the MSB; concatenation keeps this legal for WIDTH=1
  assign s_next    = WIDTH'({fa_s, sreg} >> 1);

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign sum       = sreg;
  assign cout      = creg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      areg  <= '0;
      breg  <= '0;
      sreg  <= '0;
      creg  <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            areg  <= a;
            breg  <= b;
            creg  <= cin;
            sreg  <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          areg <= areg >> 1;
          breg <= breg >> 1;
          sreg <= s_next;
          creg <= fa_c;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed and randomized checks of serial_adder against an arithmetic model
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  int vectors = 0;
  int errors  = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // wait for in_ready, then present one operand set for a single edge (or keep it up)
  task automatic accept(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc,
                        input bit keep_valid);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("accept_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    a = ta;
    b = tbv;
    cin = tc;
    tick();
    if (!keep_valid) in_valid = 1'b0;
  endtask

  // count edges to out_valid; optionally scribble on the inputs meanwhile
  task automatic wait_done(input string tag, input bit noise);
    int n = 0;
    while (!out_valid && n < 100) begin
      if (noise) begin
        in_valid = 1'($urandom);
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
      end
      tick();
      n++;
    end
    if (noise) in_valid = 1'b0;
    chk({tag, "_latency"}, 64'(n), 64'(W));
  endtask

  task automatic check_result(input string tag, input logic [W:0] exp);
    chk({tag, "_sum"}, 64'(sum), 64'(exp[W-1:0]));
    chk({tag, "_cout"}, 64'(cout), 64'(exp[W]));
  endtask

  // hold out_ready low for some cycles, then complete the output handshake
  task automatic drain(input string tag, input logic [W:0] exp, input int stall);
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_hold_res"}, 64'({cout, sum}), 64'(exp));
      chk({tag, "_hold_inrdy"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_ovalid_fall"}, 64'(out_valid), 64'd0);
    chk({tag, "_inrdy_back"}, 64'(in_ready), 64'd1);
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                        input logic tc, input int stall, input bit noise);
    logic [W:0] exp;
    exp = model(ta, tbv, tc);
    accept(ta, tbv, tc, 1'b0);
    wait_done(tag, noise);
    check_result(tag, exp);
    drain(tag, exp, stall);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;

    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'({cout, sum}), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);

    run_op("s1", 8'h0F, 8'h01, 1'b0, 0, 1'b0);
    run_op("s2a", 8'hFF, 8'h01, 1'b0, 0, 1'b0);
    run_op("s2b", 8'hFF, 8'hFF, 1'b1, 0, 1'b0);
    run_op("s3", 8'hA5, 8'h5A, 1'b0, 5, 1'b0);

    // in_valid held with a different operand while the first one is in flight
    accept(8'h01, 8'h02, 1'b0, 1'b0);
    in_valid = 1'b1;
    a = 8'h33;
    b = 8'h00;
    cin = 1'b0;
    chk("s4_busy_in_ready", 64'(in_ready), 64'd0);
    wait_done("s4", 1'b0);
    check_result("s4", 9'h003);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("s4_ready_again", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    wait_done("s4b", 1'b0);
    check_result("s4b", 9'h033);
    drain("s4b", 9'h033, 0);

    // abort mid-operation
    accept(8'h80, 8'h80, 1'b0, 1'b0);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("s5_rst_in_ready", 64'(in_ready), 64'd0);
    chk("s5_rst_out_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    #1;
    chk("s5_idle_in_ready", 64'(in_ready), 64'd1);
    repeat (12) tick();
    chk("s5_no_stale_valid", 64'(out_valid), 64'd0);
    run_op("s5b", 8'h80, 8'h80, 1'b0, 0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      run_op("rand", ra, rb, rc, int'($urandom_range(0, 3)), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
